operand_issue_queue: RTL and testbench
======================================

OPERAND_ISSUE_QUEUE -- requirements
Module: operand_issue_queue

Interface
REQ-001 Parameter: WIDTH_IN, default 16, operand width in bits.
REQ-002 Parameter: WIDTH_PRODUCT, default 32, product width in bits.
REQ-003 Parameter: DEPTH, default 4, operand-pair FIFO entries; legal values are powers of two, minimum 2.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: in_a, in_b  input  WIDTH_IN each  operand pair offered by upstream.
REQ-007 Port: in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-008 Port: in_ready  output  1  queue can accept a pair this cycle.
REQ-009 Port: mul_a, mul_b  output  WIDTH_IN each  operands driven to the Booth multiplier.
REQ-010 Port: mul_valid_in  output  1  one-cycle start pulse to the multiplier.
REQ-011 Port: mul_valid_out  input  1  multiplier done pulse; mul_product is valid while it is high.
REQ-012 Port: mul_product  input  WIDTH_PRODUCT  multiplier result.
REQ-013 Port: out_product  output  WIDTH_PRODUCT  held result for downstream.
REQ-014 Port: out_valid, out_ready  output, input  1 each  downstream result handshake.
REQ-015 Port: busy  output  1  high in any state other than IDLE.
REQ-016 Port: fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Pair accepted on in_valid && in_ready; in_ready = (fifo_count < DEPTH), with no combinational dependence on pop.
REQ-018 FSM states: IDLE, ISSUE, WAIT.
REQ-019 IDLE -> ISSUE when FIFO is non-empty and out_valid == 0; otherwise remain in IDLE.
REQ-020 On IDLE -> ISSUE: register FIFO head into mul_a/mul_b and pop the FIFO in the same edge.
REQ-021 In ISSUE, mul_valid_in = 1 for exactly one cycle; next state is WAIT.
REQ-022 mul_a/mul_b stay stable from ISSUE until the next IDLE -> ISSUE transition.
REQ-023 WAIT -> IDLE on mul_valid_out == 1: capture mul_product into out_product, and out_valid = 1 from the next cycle.
REQ-024 Ignore mul_valid_out in IDLE or ISSUE, with no state or output change.
REQ-025 out_valid holds with out_product unchanged until out_valid && out_ready, then clears next cycle.
REQ-026 At most one multiplication is in flight; no issue while a result is unconsumed.
REQ-027 Latency: pair accepted at cycle N into an empty, idle queue -> mul_valid_in high at cycle N+2.
REQ-028 Latency: result appears on out_valid one cycle after the mul_valid_out cycle.
REQ-029 Simultaneous push and pop: occupancy unchanged, pointers both advance, and FIFO order is preserved.
REQ-030 FIFO pointers wrap modulo DEPTH; full/empty are derived from fifo_count, never from pointer equality alone.
REQ-031 Product bits pass through unmodified; the block performs no arithmetic on them.

Reset
REQ-032 While reset == 0 at a clock edge, the following are cleared: FSM = IDLE, FIFO emptied (pointers and fifo_count = 0), mul_a = mul_b = 0, mul_valid_in = 0, out_product = 0, out_valid = 0, busy = 0.
REQ-033 in_ready = 0 during reset and 1 from the first cycle after release.
REQ-034 Reset mid-operation discards queued pairs and any in-flight result.
REQ-035 A mul_valid_out arriving after reset release while in IDLE is ignored.

Structure
REQ-036 Shared package booth_pkg holds: WIDTH_IN, WIDTH_PRODUCT, DEPTH defaults; the FSM state enum (IDLE, ISSUE, WAIT); and the packed operand-pair struct {a, b}.
REQ-037 The FIFO is a sub-module named operand_fifo, covering storage, pointers, count, push/pop and full/empty; FSM and result register stay in the top.

Verification
REQ-038 Single op: push a=3, b=5; stub asserts mul_valid_out 16 cycles after mul_valid_in with product 15 -> mul_valid_in at N+2, mul_a=3, mul_b=5; out_valid next cycle with out_product=0x0000000F.
REQ-039 Signed pass-through: a=0xFFFE, b=0x0007, stub product 0xFFFFFFF2 -> out_product=0xFFFFFFF2.
REQ-040 Full/backpressure: out_ready=0, push 6 pairs back-to-back -> one issue, fifo_count = 4 with in_ready=0 after the 5th accept, no second mul_valid_in until out_ready=1.
REQ-041 Ordering: push (1,2),(3,4),(5,6),(7,8), out_ready=1 -> four issues in push order; outputs 2, 12, 30, 56.
REQ-042 Reset mid-WAIT: reset low for 1 cycle during WAIT with 2 pairs queued -> IDLE, fifo_count=0, out_valid=0; a stale mul_valid_out afterward produces no output.
REQ-043 Spurious done: mul_valid_out pulsed in IDLE with empty FIFO -> out_valid stays 0, busy stays 0.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth operand issue path.
// Holds default widths/depth, the issue FSM state type and the operand-pair layout.
// No logic; imported by the queue, its FIFO and anything that models them.
package booth_pkg;

    localparam int BOOTH_WIDTH_IN      = 16;
    localparam int BOOTH_WIDTH_PRODUCT = 32;
    localparam int BOOTH_DEPTH         = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [BOOTH_WIDTH_IN-1:0] a;
        logic [BOOTH_WIDTH_IN-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/operand_fifo.sv
// Operand-pair FIFO: DEPTH entries of DW bits, combinational head read.
// Latency: a pushed entry is at the head on the next cycle when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; full/empty come from the count.
// Ports: clk_i/rst_ni (sync, active-low), push_i/push_dat_i, pop_i/pop_dat_o,
//        count_o (occupancy), full_o, empty_o.
module operand_fifo
    import booth_pkg::*;
#(
    parameter int DW    = 2 * BOOTH_WIDTH_IN,
    parameter int DEPTH = BOOTH_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_dat_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    // DEPTH is a power of two, so the pointers wrap for free at AW bits.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Pointers alone cannot tell full from empty; the count is authoritative.
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/operand_issue_queue.sv
// Operand issue queue: buffers operand pairs and feeds a Booth multiplier one at a time.
// Latency: accept at N -> mul_valid_in at N+2; mul_valid_out at M -> out_valid at M+1.
// Backpressure: in_ready drops when the FIFO is full; no issue while a result is unconsumed.
// Ports: clk/reset (sync, active-low); in_a/in_b/in_valid/in_ready upstream;
//        mul_a/mul_b/mul_valid_in/mul_valid_out/mul_product to/from the multiplier;
//        out_product/out_valid/out_ready downstream; busy, fifo_count status.
module operand_issue_queue
    import booth_pkg::*;
#(
    parameter int WIDTH_IN      = BOOTH_WIDTH_IN,
    parameter int WIDTH_PRODUCT = BOOTH_WIDTH_PRODUCT,
    parameter int DEPTH         = BOOTH_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH_IN-1:0]      in_a,
    input  logic [WIDTH_IN-1:0]      in_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH_IN-1:0]      mul_a,
    output logic [WIDTH_IN-1:0]      mul_b,
    output logic                     mul_valid_in,
    input  logic                     mul_valid_out,
    input  logic [WIDTH_PRODUCT-1:0] mul_product,
    output logic [WIDTH_PRODUCT-1:0] out_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    issue_state_e             state_q, state_d;
    logic [WIDTH_IN-1:0]      mul_a_q, mul_a_d;
    logic [WIDTH_IN-1:0]      mul_b_q, mul_b_d;
    logic [WIDTH_PRODUCT-1:0] out_product_q, out_product_d;
    logic                     out_valid_q, out_valid_d;

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [2*WIDTH_IN-1:0]    fifo_head;

    // Ready depends only on the registered count (and reset), never on this cycle's pop.
    assign in_ready  = reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    operand_fifo #(
        .DW    (2 * WIDTH_IN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .push_i     (fifo_push),
        .push_dat_i ({in_a, in_b}),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_product_d = out_product_q;
        out_valid_d   = out_valid_q;
        fifo_pop      = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A held result blocks the next issue so only one product is ever pending.
                if (!fifo_empty && !out_valid_q) begin
                    state_d  = ISSUE;
                    fifo_pop = 1'b1;
                    mul_a_d  = fifo_head[2*WIDTH_IN-1:WIDTH_IN];
                    mul_b_d  = fifo_head[WIDTH_IN-1:0];
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_valid_out) begin
                    state_d       = IDLE;
                    out_product_d = mul_product;
                    out_valid_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_product_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_product_q <= out_product_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_valid_in = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign out_product  = out_product_q;
    assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_operand_issue_queue.sv
// Testbench for operand_issue_queue: directed cases plus randomized traffic.
// A multiplier stub answers each start pulse; a queue-based model predicts every cycle.
// Outputs are sampled on the falling edge; inputs change 1-2 time units after the rising edge.
module tb_operand_issue_queue;
    import booth_pkg::*;

    localparam int WI    = BOOTH_WIDTH_IN;
    localparam int WP    = BOOTH_WIDTH_PRODUCT;
    localparam int DEPTH = BOOTH_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [WI-1:0]          in_a, in_b;
    logic                   in_valid, in_ready;
    logic [WI-1:0]          mul_a, mul_b;
    logic                   mul_valid_in, mul_valid_out;
    logic [WP-1:0]          mul_product, out_product;
    logic                   out_valid, out_ready, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    operand_issue_queue #(.WIDTH_IN(WI), .WIDTH_PRODUCT(WP), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_ready(in_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_valid_in(mul_valid_in),
        .mul_valid_out(mul_valid_out), .mul_product(mul_product), .out_product(out_product),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .fifo_count(fifo_count)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Signed product of a pair, sign-extended to the product width.
    function automatic logic [WP-1:0] ref_prod(input operand_pair_t p);
        logic signed [WP-1:0] sa, sb;
        sa = {{(WP-WI){p.a[WI-1]}}, p.a};
        sb = {{(WP-WI){p.b[WI-1]}}, p.b};
        return WP'(sa * sb);
    endfunction

    // ---------------- multiplier stub ----------------
    int            stub_lat  = 16;
    bit            stub_rnd  = 1'b0;
    int            spur_req  = 0;
    int            spur_done = 0;
    int            lat;
    operand_pair_t stub_pair;

    initial begin
        mul_valid_out = 1'b0;
        mul_product   = '0;
        forever begin
            @(posedge clk); #1;
            mul_valid_out = 1'b0;
            mul_product   = WP'($urandom);
            if (spur_req != spur_done) begin
                spur_done++;
                mul_valid_out = 1'b1;
            end else if (mul_valid_in === 1'b1) begin
                stub_pair.a = mul_a;
                stub_pair.b = mul_b;
                lat = stub_rnd ? int'($urandom_range(5, 1)) : stub_lat;
                repeat (lat) begin @(posedge clk); #1; end
                mul_product   = ref_prod(stub_pair);
                mul_valid_out = 1'b1;
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    bit rnd_rdy   = 1'b0;
    bit rdy_force = 1'b0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            out_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : rdy_force;
        end
    end

    // ---------------- reference model / monitor ----------------
    operand_pair_t mdl_q[$];
    operand_pair_t acc_pair, head;
    bit            acc_prev, exp_iss, inflight, res_pend, done_prev;
    logic [WP-1:0] exp_prod;
    logic [WI-1:0] cur_a, cur_b;
    logic [WP-1:0] out_log[$];
    int            iss_cnt = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mdl_q.delete();
            acc_prev  = 1'b0;
            exp_iss   = 1'b0;
            inflight  = 1'b0;
            res_pend  = 1'b0;
            done_prev = 1'b0;
            exp_prod  = '0;
            cur_a     = '0;
            cur_b     = '0;
        end else begin
            if (acc_prev) mdl_q.push_back(acc_pair);
            chk("issue_pulse", mul_valid_in, exp_iss);
            if (mul_valid_in) begin
                iss_cnt++;
                chk("one_in_flight", inflight || res_pend, 0);
                chk("issue_nonempty", mdl_q.size() > 0, 1);
                if (mdl_q.size() > 0) begin
                    head = mdl_q.pop_front();
                    chk("issue_a", mul_a, head.a);
                    chk("issue_b", mul_b, head.b);
                    exp_prod = ref_prod(head);
                    cur_a    = head.a;
                    cur_b    = head.b;
                end
                inflight = 1'b1;
            end
            if (done_prev) begin
                inflight = 1'b0;
                res_pend = 1'b1;
            end
            chk("out_valid", out_valid, res_pend);
            if (res_pend) chk("out_product", out_product, exp_prod);
            chk("fifo_count", fifo_count, mdl_q.size());
            chk("in_ready", in_ready, mdl_q.size() < DEPTH);
            chk("busy", busy, inflight);
            chk("mul_ab_hold", {mul_a, mul_b}, {cur_a, cur_b});
            exp_iss = (mdl_q.size() > 0) && !inflight && !res_pend;
            if (res_pend && out_ready) begin
                out_log.push_back(out_product);
                res_pend = 1'b0;
            end
            done_prev  = mul_valid_out && inflight && !mul_valid_in;
            acc_prev   = in_valid && in_ready;
            acc_pair.a = in_a;
            acc_pair.b = in_b;
        end
    end

    // ---------------- stimulus helpers ----------------
    int acc_cyc, iss_cyc, out_cyc, base, log_base;
    bit seen;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves in_valid high so consecutive calls present pairs back-to-back.
    task automatic push(input logic [WI-1:0] a, input logic [WI-1:0] b);
        int w = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && w < 200) begin tick(); w++; end
        chk("push_accept", in_ready, 1);
        acc_cyc = cyc;
        tick();
    endtask

    task automatic wait_issue();
        int w = 0;
        while (mul_valid_in !== 1'b1 && w < 60) begin tick(); w++; end
        chk("issue_seen", mul_valid_in, 1);
        iss_cyc = cyc;
    endtask

    task automatic wait_out();
        int w = 0;
        while (out_valid !== 1'b1 && w < 60) begin tick(); w++; end
        chk("out_seen", out_valid, 1);
        out_cyc = cyc;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (!(fifo_count == 0 && busy == 1'b0 && out_valid == 1'b0) && w < 3000) begin
            tick(); w++;
        end
        chk(tag, (fifo_count == 0 && busy == 1'b0 && out_valid == 1'b0), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_mul_valid_in", mul_valid_in, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_out_product", out_product, 0);
        reset = 1'b1; #1;
        chk("rel_in_ready", in_ready, 1);
        rdy_force = 1'b1;
        tick(); tick();

        // Single op with exact latencies
        stub_lat = 16;
        push(16'd3, 16'd5);
        in_valid = 1'b0;
        wait_issue();
        chk("lat_issue", iss_cyc - acc_cyc, 2);
        chk("single_a", mul_a, 3);
        chk("single_b", mul_b, 5);
        wait_out();
        chk("lat_out", out_cyc - iss_cyc, 17);
        chk("single_prod", out_product, 32'h0000000F);
        tick();
        chk("single_clear", out_valid, 0);
        drain("drain_single");

        // Signed pass-through
        stub_lat = 4;
        push(16'hFFFE, 16'h0007);
        in_valid = 1'b0;
        wait_out();
        chk("signed_prod", out_product, 32'hFFFFFFF2);
        drain("drain_signed");

        // Full / backpressure
        rdy_force = 1'b0; stub_lat = 3; base = iss_cnt;
        tick();
        for (int i = 0; i < 5; i++) push(WI'(i + 10), WI'(i + 20));
        chk("full_count", fifo_count, 4);
        chk("full_ready", in_ready, 0);
        in_a = 16'd15; in_b = 16'd25;
        repeat (20) tick();
        chk("bp_issues", iss_cnt - base, 1);
        chk("bp_out_hold", out_valid, 1);
        chk("bp_still_full", in_ready, 0);
        rdy_force = 1'b1;
        push(16'd15, 16'd25);
        in_valid = 1'b0;
        drain("drain_bp");
        chk("bp_total_issues", iss_cnt - base, 6);

        // Ordering
        log_base = out_log.size();
        for (int i = 0; i < 4; i++) push(WI'(2 * i + 1), WI'(2 * i + 2));
        in_valid = 1'b0;
        drain("drain_order");
        chk("order_n", out_log.size() - log_base, 4);
        if (out_log.size() - log_base == 4) begin
            chk("order_0", out_log[log_base + 0], 2);
            chk("order_1", out_log[log_base + 1], 12);
            chk("order_2", out_log[log_base + 2], 30);
            chk("order_3", out_log[log_base + 3], 56);
        end

        // Reset mid-WAIT with two pairs queued
        stub_lat = 10;
        push(16'd9, 16'd9); push(16'd2, 16'd3); push(16'd4, 16'd5);
        in_valid = 1'b0;
        tick(); tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_count", fifo_count, 2);
        base = iss_cnt;
        reset = 1'b0; #1;
        chk("mid_rst_ready", in_ready, 0);
        tick();
        reset = 1'b1; #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(); seen |= out_valid; end
        chk("stale_done_ignored", seen, 0);
        chk("no_issue_after_rst", iss_cnt - base, 0);

        // Spurious done in IDLE
        spur_req++;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= (out_valid | busy); end
        chk("spurious_ignored", seen, 0);

        // Randomized traffic
        stub_rnd = 1'b1; rnd_rdy = 1'b1;
        log_base = out_log.size();
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(2, 0)) tick();
            push(WI'($urandom), WI'($urandom));
        end
        in_valid = 1'b0;
        drain("drain_random");
        chk("random_count", out_log.size() - log_base, 60);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
